hazard_stall_ctrl: RTL and testbench

Pipeline hazard controller. It produces the bubble-select that drives the ID-stage control-signal mux, which zeroes ALUSrc/ALUOp/RegDst/MemWr/MemRd/MemtoReg/RegWr. It also drives PC and IF/ID write enables and the IF/ID flush. It detects load-use hazards, freezes the whole pipe on data-memory stalls, and flushes IF/ID on taken branch or jump. It keeps a watchdog on memory stalls and a saturating bubble counter for performance monitoring.

---
 rtl/hazard_stall_ctrl_pkg.sv | 21 ++
 rtl/hazard_stall_ctrl_sat_counter.sv | 41 ++++
 rtl/hazard_stall_ctrl.sv | 155 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl_pkg
//   Shared definitions for the pipeline hazard/stall controller:
//     - controller state encoding
//     - register-index width and the hard-wired $zero register index
// -----------------------------------------------------------------------------
package hazard_stall_ctrl_pkg;

  // Register-index width of the ID/EX register fields compared for hazards.
  localparam int REG_W = 5;

  // Register 0 always reads zero, so a load targeting it never creates a hazard.
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    LU_BUBBLE = 2'b01,
    MEM_WAIT  = 2'b10
  } state_e;

endpackage : hazard_stall_ctrl_pkg

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up-counter that stops at MAX_VAL instead of wrapping.
//   Ports:
//     i_clk    clock, rising edge
//     i_rst    asynchronous active-high reset (count -> 0)
//     i_en     count enable
//     i_clr    synchronous clear, takes priority over i_en
//     o_count  current count
//     o_sat    high while the count equals MAX_VAL
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned           WIDTH   = 8,
  parameter logic [WIDTH-1:0]      MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count,
  output logic             o_sat
);

  logic [WIDTH-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_sat) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;
  assign o_sat   = (r_count == MAX_VAL);

endmodule : sat_counter

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//   ID-stage hazard controller. Detects load-use hazards (inserts a bubble via
//   the control-signal mux), freezes the whole pipe on data-memory stalls,
//   flushes IF/ID on a taken branch or jump, watches for stuck memory stalls
//   and counts load-use bubbles. All pipeline controls are combinational so
//   they take effect in the cycle the condition is seen.
//   Register-index width (REG_W) comes from hazard_stall_ctrl_pkg.
//
//   Ports:
//     clk_i, rst_i             clock (rising edge), async active-high reset
//     IDEX_MemRd_i, IDEX_Rt_i  load in EX and its destination register
//     IFID_Rs_i, IFID_Rt_i     source registers of the instruction in ID
//     IFID_UsesRt_i            ID instruction actually reads rt
//     Branch_i, Jump_i         taken branch / jump resolved in ID
//     mem_stall_i              data memory not ready this cycle
//     select_o                 1 = control mux drives zeros (bubble)
//     PCWrite_o, IFIDWrite_o   PC and IF/ID write enables
//     IFIDFlush_o              clear IF/ID to NOP on next edge
//     pipe_stall_o             freeze ID/EX, EX/MEM, MEM/WB
//     timeout_o                sticky memory-stall watchdog flag
//     bubble_cnt_o             saturating load-use bubble count
// -----------------------------------------------------------------------------
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int WDOG_MAX = 64,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRd_i,
  input  logic [REG_W-1:0] IDEX_Rt_i,
  input  logic [REG_W-1:0] IFID_Rs_i,
  input  logic [REG_W-1:0] IFID_Rt_i,
  input  logic             IFID_UsesRt_i,
  input  logic             Branch_i,
  input  logic             Jump_i,
  input  logic             mem_stall_i,
  output logic             select_o,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFIDFlush_o,
  output logic             pipe_stall_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  localparam int unsigned WDOG_W = $clog2(WDOG_MAX + 1);

  state_e r_state;
  state_e w_next_state;

  logic              w_lu;
  logic              w_wdog_en;
  logic              w_wdog_clr;
  logic              w_wdog_sat;
  logic [WDOG_W-1:0] w_wdog_cnt_unused;
  logic              w_bubble_en;
  logic              w_bubble_sat_unused;
  logic              r_timeout;

  // A load in EX whose destination feeds the ID instruction; $zero is exempt
  // and rt only matters when the ID instruction actually reads it.
  assign w_lu = IDEX_MemRd_i && (IDEX_Rt_i != ZERO_REG) &&
                ((IDEX_Rt_i == IFID_Rs_i) ||
                 (IFID_UsesRt_i && (IDEX_Rt_i == IFID_Rt_i)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Every state leaves on the same conditions: a memory stall dominates, a
  // load-use hazard (including a second one while in LU_BUBBLE) costs one
  // bubble cycle, anything else runs.
  // NOTE: every always_comb output gets a default first so no path through
  // the block leaves a signal unassigned (which would infer a latch).
  always_comb begin
    w_next_state = RUN;
    select_o     = 1'b0;
    PCWrite_o    = 1'b1;
    IFIDWrite_o  = 1'b1;
    IFIDFlush_o  = 1'b0;
    pipe_stall_o = 1'b0;

    if (rst_i) begin
      select_o    = 1'b1;
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
    end else if (mem_stall_i) begin
      // Whole pipe holds: no bubble, no flush, nothing advances.
      w_next_state = MEM_WAIT;
      pipe_stall_o = 1'b1;
      PCWrite_o    = 1'b0;
      IFIDWrite_o  = 1'b0;
    end else if (w_lu) begin
      // A branch/jump in ID is ignored here; it re-evaluates after the bubble.
      w_next_state = LU_BUBBLE;
      select_o     = 1'b1;
      PCWrite_o    = 1'b0;
      IFIDWrite_o  = 1'b0;
    end else if (Branch_i || Jump_i) begin
      IFIDFlush_o  = 1'b1;
    end
  end

  // Watchdog: counts consecutive stall cycles, cleared on the release cycle.
  assign w_wdog_en  = mem_stall_i;
  assign w_wdog_clr = (r_state == MEM_WAIT) && !mem_stall_i;

  // Only the saturate flag of the watchdog matters; its count is not exported.
  sat_counter #(
    .WIDTH   (WDOG_W),
    .MAX_VAL (WDOG_W'(WDOG_MAX))
  ) u_wdog_cnt (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_en    (w_wdog_en),
    .i_clr   (w_wdog_clr),
    .o_count (w_wdog_cnt_unused),
    .o_sat   (w_wdog_sat)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_timeout <= 1'b0;
    end else if (w_wdog_sat) begin
      r_timeout <= 1'b1;
    end
  end

  // The flag shows in the same cycle the counter reaches WDOG_MAX and is then
  // held by r_timeout after the counter clears.
  assign timeout_o = r_timeout || w_wdog_sat;

  // A bubble is only inserted when the hazard is not masked by a mem stall.
  assign w_bubble_en = w_lu && !mem_stall_i;

  sat_counter #(
    .WIDTH   (CNT_W),
    .MAX_VAL ({CNT_W{1'b1}})
  ) u_bubble_cnt (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_en    (w_bubble_en),
    .i_clr   (1'b0),
    .o_count (bubble_cnt_o),
    .o_sat   (w_bubble_sat_unused)
  );

endmodule : hazard_stall_ctrl

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//   Directed bench for hazard_stall_ctrl with a small WDOG_MAX and a narrow
//   bubble counter so watchdog and counter saturation are reached quickly.
//   Each step drives inputs just after a rising edge, pushes the expected
//   outputs from a behavioural model onto a scoreboard queue, then pops and
//   compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;
  import hazard_stall_ctrl_pkg::*;

  localparam int WDOG = 4;
  localparam int CW   = 3;
  localparam int BMAX = (1 << CW) - 1;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             IDEX_MemRd_i;
  logic [REG_W-1:0] IDEX_Rt_i;
  logic [REG_W-1:0] IFID_Rs_i;
  logic [REG_W-1:0] IFID_Rt_i;
  logic             IFID_UsesRt_i;
  logic             Branch_i;
  logic             Jump_i;
  logic             mem_stall_i;
  logic             select_o;
  logic             PCWrite_o;
  logic             IFIDWrite_o;
  logic             IFIDFlush_o;
  logic             pipe_stall_o;
  logic             timeout_o;
  logic [CW-1:0]    bubble_cnt_o;

  hazard_stall_ctrl #(
    .WDOG_MAX (WDOG),
    .CNT_W    (CW)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .IDEX_MemRd_i  (IDEX_MemRd_i),
    .IDEX_Rt_i     (IDEX_Rt_i),
    .IFID_Rs_i     (IFID_Rs_i),
    .IFID_Rt_i     (IFID_Rt_i),
    .IFID_UsesRt_i (IFID_UsesRt_i),
    .Branch_i      (Branch_i),
    .Jump_i        (Jump_i),
    .mem_stall_i   (mem_stall_i),
    .select_o      (select_o),
    .PCWrite_o     (PCWrite_o),
    .IFIDWrite_o   (IFIDWrite_o),
    .IFIDFlush_o   (IFIDFlush_o),
    .pipe_stall_o  (pipe_stall_o),
    .timeout_o     (timeout_o),
    .bubble_cnt_o  (bubble_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic          sel;
    logic          pcw;
    logic          ifw;
    logic          fl;
    logic          ps;
    logic          to;
    logic [CW-1:0] bc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Behavioural model of the registered state visible at the outputs.
  int   m_stall = 0;
  logic m_to    = 1'b0;
  int   m_bub   = 0;

  function automatic logic ref_lu();
    if (!IDEX_MemRd_i || IDEX_Rt_i == '0) return 1'b0;
    if (IDEX_Rt_i == IFID_Rs_i) return 1'b1;
    return IFID_UsesRt_i && (IDEX_Rt_i == IFID_Rt_i);
  endfunction

  task automatic model_reset();
    m_stall = 0;
    m_to    = 1'b0;
    m_bub   = 0;
  endtask

  // Effect of the coming rising edge with the current inputs held.
  task automatic model_edge();
    if (rst_i) begin
      model_reset();
    end else begin
      if (mem_stall_i) begin
        if (m_stall < WDOG) m_stall++;
        if (m_stall == WDOG) m_to = 1'b1;
      end else begin
        m_stall = 0;
        if (ref_lu() && m_bub < BMAX) m_bub++;
      end
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e = '0;
    if (rst_i) begin
      e.sel = 1'b1;
    end else if (mem_stall_i) begin
      e.ps = 1'b1;
    end else if (ref_lu()) begin
      e.sel = 1'b1;
    end else if (Branch_i || Jump_i) begin
      e.fl  = 1'b1;
      e.pcw = 1'b1;
      e.ifw = 1'b1;
    end else begin
      e.pcw = 1'b1;
      e.ifw = 1'b1;
    end
    e.to = m_to;
    e.bc = m_bub[CW-1:0];
    sb_q.push_back(e);
  endtask

  task automatic cmp(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
      return;
    end
    e = sb_q.pop_front();
    cmp({tag, ".select"},    {{(CW-1){1'b0}}, select_o},     {{(CW-1){1'b0}}, e.sel});
    cmp({tag, ".pcwrite"},   {{(CW-1){1'b0}}, PCWrite_o},    {{(CW-1){1'b0}}, e.pcw});
    cmp({tag, ".ifidwrite"}, {{(CW-1){1'b0}}, IFIDWrite_o},  {{(CW-1){1'b0}}, e.ifw});
    cmp({tag, ".flush"},     {{(CW-1){1'b0}}, IFIDFlush_o},  {{(CW-1){1'b0}}, e.fl});
    cmp({tag, ".pipestall"}, {{(CW-1){1'b0}}, pipe_stall_o}, {{(CW-1){1'b0}}, e.ps});
    cmp({tag, ".timeout"},   {{(CW-1){1'b0}}, timeout_o},    {{(CW-1){1'b0}}, e.to});
    cmp({tag, ".bubbles"},   bubble_cnt_o,                   e.bc);
  endtask

  // One cycle: drive after the rising edge, check on the falling edge.
  task automatic step(input string tag, input logic r, input logic ms,
                      input logic mr, input logic [REG_W-1:0] xrt,
                      input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                      input logic ut, input logic br, input logic jp);
    @(posedge clk_i);
    #1;
    rst_i         = r;
    mem_stall_i   = ms;
    IDEX_MemRd_i  = mr;
    IDEX_Rt_i     = xrt;
    IFID_Rs_i     = rs;
    IFID_Rt_i     = rt;
    IFID_UsesRt_i = ut;
    Branch_i      = br;
    Jump_i        = jp;
    if (r) model_reset();
    push_expected();
    @(negedge clk_i);
    check_out(tag);
    model_edge();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=no_finish expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst_i = 1'b1; mem_stall_i = 1'b0; IDEX_MemRd_i = 1'b0; IDEX_Rt_i = '0;
    IFID_Rs_i = '0; IFID_Rt_i = '0; IFID_UsesRt_i = 1'b0; Branch_i = 1'b0; Jump_i = 1'b0;

    //   tag             r  ms mr xrt rs rt ut br jp
    step("reset",        1, 0, 0, 0,  0, 0, 0, 0, 0);
    step("normal0",      0, 0, 0, 0,  0, 0, 0, 0, 0);
    step("lu_rs",        0, 0, 1, 8,  8, 2, 0, 0, 0);
    step("after_lu",     0, 0, 0, 8,  8, 2, 0, 0, 0);
    step("rt_unused",    0, 0, 1, 9,  3, 9, 0, 0, 0);
    step("rt_used",      0, 0, 1, 9,  3, 9, 1, 0, 0);
    step("zero_reg",     0, 0, 1, 0,  0, 0, 1, 0, 0);
    step("no_load",      0, 0, 0, 7,  7, 7, 1, 0, 0);

    // Memory stall dominates a load-use hazard and a taken branch.
    step("ms_lu_br1",    0, 1, 1, 8,  8, 1, 0, 1, 0);
    step("ms_lu_br2",    0, 1, 1, 8,  8, 1, 0, 1, 0);
    step("ms_lu_br3",    0, 1, 1, 8,  8, 1, 0, 1, 0);
    step("ms_release",   0, 0, 1, 8,  8, 1, 0, 1, 0);
    step("ms_after",     0, 0, 0, 8,  8, 1, 0, 1, 0);
    step("normal1",      0, 0, 0, 0,  0, 0, 0, 0, 0);

    step("branch",       0, 0, 0, 0,  4, 5, 1, 1, 0);
    step("post_branch",  0, 0, 0, 0,  4, 5, 1, 0, 0);
    step("jump",         0, 0, 0, 0,  0, 0, 0, 0, 1);
    step("post_jump",    0, 0, 0, 0,  0, 0, 0, 0, 0);

    // Watchdog: WDOG stall edges raise timeout, which then sticks.
    for (int i = 1; i <= 6; i++) begin
      step($sformatf("wdog_stall%0d", i), 0, 1, 0, 0, 0, 0, 0, 0, 0);
    end
    step("wdog_rel1",    0, 0, 0, 0,  0, 0, 0, 0, 0);
    step("wdog_rel2",    0, 0, 0, 0,  0, 0, 0, 0, 0);

    // Back-to-back independent loads, pushing the bubble counter to saturation.
    for (int i = 1; i <= 6; i++) begin
      step($sformatf("lu_b2b%0d", i), 0, 0, 1, 5'(10 + i), 5'(10 + i), 0, 0, 0, 0);
    end
    step("bub_sat",      0, 0, 0, 0,  0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a stall.
    step("pre_rst_ms1",  0, 1, 1, 3,  3, 0, 0, 0, 0);
    step("pre_rst_ms2",  0, 1, 1, 3,  3, 0, 0, 0, 0);
    #2;
    rst_i = 1'b1;
    model_reset();
    push_expected();
    #1;
    check_out("async_rst");
    model_edge();
    step("rst_hold",     1, 1, 1, 3,  3, 0, 0, 0, 0);
    step("post_rst",     0, 0, 0, 0,  0, 0, 0, 0, 0);
    n_cmp++;
    assert (dut.r_state === RUN)
    else begin
      n_err++;
      $error("FAIL post_rst.state observed=%0d expected=%0d", dut.r_state, RUN);
    end
    step("post_rst_lu",  0, 0, 1, 6,  0, 6, 1, 0, 0);
    step("final",        0, 0, 0, 0,  0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_hazard_stall_ctrl
